// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle MIPS control sequencer. Steps one instruction at a time
//   through FETCH/DECODE/execute/memory/write-back states and decodes the
//   datapath control lines from the current state plus mem_ready and zero.
//   Supports R-type, lw, sw and beq. Memory states use a req/ready handshake
//   guarded by a watchdog; an illegal opcode or a watchdog expiry parks the
//   sequencer in TRAP until reset.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   op[5:0]             opcode field from the instruction register
//   zero                ALU zero flag (beq decision)
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_we     memory request / write qualifier
//   i_or_d              memory address source (0 PC, 1 ALUOut)
//   ir_write, pc_en     IR load / PC load pulses
//   pc_source           PC source (0 ALU result, 1 ALUOut)
//   alu_src_a/b, alu_op ALU operand and operation selects
//   reg_dst, mem_to_reg, reg_write  register file write controls
//   instr_done          pulse in the final cycle of each instruction
//   illegal_op          sticky: unsupported opcode decoded
//   mem_timeout         sticky: memory watchdog expired
//   state[3:0]          current state code (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_en,
   output logic       pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_INIT      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_TRAP      = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // A zero timeout still needs a one-bit counter to keep widths legal;
   // the compare is gated off in that case.
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam bit WD_EN = (MEM_TIMEOUT > 0);

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          illegal_q, illegal_d;
   logic          timeout_q, timeout_d;
   logic          wd_expire;
   logic          in_mem_q, in_mem_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
      end
   end

   // Watchdog fires on the last allowed wait cycle; a same-cycle ready wins
   // because each memory state checks mem_ready before wd_expire.
   assign wd_expire = WD_EN && (wait_cnt_q == CNT_LAST) && !mem_ready;

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_source  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      unique case (state_q)
         S_INIT: state_d = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = S_DECODE;
            end else if (wd_expire) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut here.
            alu_src_b = 2'b11;
            if (op == OP_LW || op == OP_SW) state_d = S_MEM_ADDR;
            else if (op == OP_RTYPE)        state_d = S_EXECUTE;
            else if (op == OP_BEQ)          state_d = S_BRANCH;
            else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // IR is not written here, so op still holds the decoded opcode.
            if (op == OP_LW)      state_d = S_MEM_READ;
            else if (op == OP_SW) state_d = S_MEM_WRITE;
            else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_MEM_READ: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
            else if (wd_expire) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (wd_expire) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_source  = 1'b1;
            pc_en      = zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   // Wait counter: cleared on any ready cycle and on entry to a memory
   // state, counts not-ready cycles while in one.
   assign in_mem_q = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
   assign in_mem_d = (state_d == S_FETCH) || (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE);

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (mem_ready)                          wait_cnt_d = '0;
      else if (in_mem_d && state_d != state_q) wait_cnt_d = '0;
      else if (in_mem_q)                      wait_cnt_d = wait_cnt_q + CW'(1);
   end

   assign illegal_op  = illegal_q;
   assign mem_timeout = timeout_q;
   assign state       = state_q;

endmodule
